// File: rtl/shift_seq_nbit.sv
// shift_seq_nbit: multi-cycle shifter that resolves one barrel stage per clock.
// Modes: logical right, arithmetic right, logical left, rotate right.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   op                    00 lsr, 01 asr, 10 lsl, 11 ror
//   A, B                  operand and unsigned shift amount, sampled at accept
//   out_valid / out_ready result handshake; Y holds the last result
//   busy                  high while shifting or holding a result
module shift_seq_nbit #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned SHIFT_WIDTH = $clog2(WIDTH),
    parameter bit          SATURATE    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);

    localparam int unsigned KW = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;
    localparam int unsigned CW = SHIFT_WIDTH + 1;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_LSL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       work_q, work_d;
    logic [SHIFT_WIDTH-1:0] amt_q, amt_d;
    logic [1:0]             op_q, op_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WIDTH-1:0]       y_d;
    logic                   out_valid_d;
    logic                   busy_d;

    logic [CW-1:0]          sh;
    logic [WIDTH-1:0]       stage_res;
    logic [WIDTH-1:0]       stage_val;
    logic                   sat;

    // Amount at or beyond WIDTH; rotate ignores it and wraps modulo WIDTH.
    assign sat = SATURATE && (|B[WIDTH-1:SHIFT_WIDTH]);

    // Single stage k: shift by 2^k in the latched mode, or pass through.
    always_comb begin
        sh = CW'(1) << k_q;
        unique case (op_q)
            OP_LSR:  stage_res = work_q >> sh;
            OP_ASR:  stage_res = WIDTH'($signed(work_q) >>> sh);
            OP_LSL:  stage_res = work_q << sh;
            default: stage_res = (work_q >> sh) | (work_q << (CW'(WIDTH) - sh));
        endcase
        stage_val = amt_q[k_q] ? stage_res : work_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        amt_d       = amt_q;
        op_d        = op_q;
        k_d         = k_q;
        y_d         = Y;
        out_valid_d = out_valid;
        busy_d      = busy;
        in_ready    = (state_q == S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = A;
                    op_d    = op;
                    amt_d   = B[SHIFT_WIDTH-1:0];
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                    // Saturated result is preloaded; the stages then pass it through.
                    if (sat && (op != OP_ROR)) begin
                        amt_d  = '0;
                        work_d = (op == OP_ASR) ? {WIDTH{A[WIDTH-1]}} : '0;
                    end
                end
            end
            S_SHIFT: begin
                work_d = stage_val;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(SHIFT_WIDTH - 1)) begin
                    k_d         = '0;
                    y_d         = stage_val;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            amt_q     <= '0;
            op_q      <= '0;
            k_q       <= '0;
            Y         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            amt_q     <= amt_d;
            op_q      <= op_d;
            k_q       <= k_d;
            Y         <= y_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_nbit.sv
// Bench for shift_seq_nbit: three instances (64-bit saturating, 64-bit
// non-saturating, 8-bit saturating) driven in lockstep from shared inputs and
// checked against a bit-at-a-time reference model.
module tb_shift_seq_nbit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        ir0, ov0, bz0;
    logic [63:0] y0;
    logic        ir1, ov1, bz1;
    logic [63:0] y1;
    logic        ir8, ov8, bz8;
    logic [7:0]  y8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_seq_nbit #(.WIDTH(64), .SHIFT_WIDTH(6), .SATURATE(1'b1)) u_sat64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .op(op),
        .A(a), .B(b), .out_valid(ov0), .out_ready(out_ready), .Y(y0), .busy(bz0));

    shift_seq_nbit #(.WIDTH(64), .SHIFT_WIDTH(6), .SATURATE(1'b0)) u_nosat64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .op(op),
        .A(a), .B(b), .out_valid(ov1), .out_ready(out_ready), .Y(y1), .busy(bz1));

    shift_seq_nbit #(.WIDTH(8), .SHIFT_WIDTH(3), .SATURATE(1'b1)) u_sat8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .op(op),
        .A(a[7:0]), .B(b[7:0]), .out_valid(ov8), .out_ready(out_ready), .Y(y8), .busy(bz8));

    // Reference: shift one bit position at a time, amt times.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] av,
                                          input logic [63:0] bv, input bit sat, input int w);
        logic [63:0] mask, r, msb;
        int amt;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        av   = av & mask;
        bv   = bv & mask;
        msb  = 64'(av[w-1]);
        if (sat && (bv >= 64'(w)) && (o != 2'd3))
            return (o == 2'd1 && msb[0]) ? mask : 64'd0;
        amt = int'(bv % 64'(w));
        r   = av;
        for (int i = 0; i < amt; i++) begin
            case (o)
                2'd0:    r = r >> 1;
                2'd1:    r = (r >> 1) | (msb << (w - 1));
                2'd2:    r = (r << 1) & mask;
                default: r = (r >> 1) | (64'(r[0]) << (w - 1));
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request in IDLE and take the accept edge.
    task automatic send(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        chk("in_ready_idle", 64'({ir0, ir1, ir8}), 64'b111);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
        chk("busy_after_accept", 64'({bz0, bz1, bz8, ir0}), 64'b1110);
    endtask

    // Wait for both widths to finish, checking latency and results.
    task automatic wait_done(input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e8);
        int lat = 0;
        int lat8 = -1;
        while (!(ov0 && ov8) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ov8 && lat8 < 0) lat8 = lat;
        end
        chk("latency64", 64'(lat), 64'd6);
        chk("latency8", 64'(lat8), 64'd3);
        chk("out_valid_nosat", 64'(ov1), 64'd1);
        chk("in_ready_done", 64'({ir0, ir1, ir8}), 64'd0);
        chk("y_sat64", y0, e0);
        chk("y_nosat64", y1, e1);
        chk("y_sat8", 64'(y8), e8);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_cleared", 64'({ov0, ov1, ov8}), 64'd0);
        chk("idle_again", 64'({ir0, ir1, ir8, bz0, bz1, bz8}), 64'b111000);
    endtask

    task automatic run(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] e0, e1, e8;
        e0 = model(o, av, bv, 1'b1, 64);
        e1 = model(o, av, bv, 1'b0, 64);
        e8 = model(o, av, bv, 1'b1, 8);
        send(o, av, bv);
        wait_done(e0, e1, e8);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ra, rb, ea, eb, ea1, eb1, ea8, eb8;
        logic [1:0]  ro, ro2;

        // Reset values while rst_n is held low.
        #12;
        chk("reset_y", y0 | y1 | 64'(y8), 64'd0);
        chk("reset_flags", 64'({ov0, ov1, ov8, bz0, bz1, bz8}), 64'd0);
        chk("reset_in_ready", 64'({ir0, ir1, ir8}), 64'b111);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        run(2'd0, 64'hF000_0000_0000_0001, 64'd4);
        chk("plan_lsr4", y0, 64'h0F00_0000_0000_0000);
        run(2'd1, 64'h8000_0000_0000_0000, 64'd63);
        chk("plan_asr63", y0, 64'hFFFF_FFFF_FFFF_FFFF);
        run(2'd0, 64'h8000_0000_0000_0000, 64'd63);
        chk("plan_lsr63", y0, 64'h1);
        run(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64);
        chk("plan_sat_lsr", y0, 64'h0);
        chk("plan_nosat_lsr", y1, 64'hFFFF_FFFF_FFFF_FFFF);
        run(2'd1, 64'h8000_0000_0000_0000, 64'd64);
        chk("plan_sat_asr", y0, 64'hFFFF_FFFF_FFFF_FFFF);
        run(2'd3, 64'h1, 64'd64);
        chk("plan_sat_ror", y0, 64'h1);
        run(2'd2, 64'h1, 64'd63);
        chk("plan_lsl63", y0, 64'h8000_0000_0000_0000);
        run(2'd3, 64'h1, 64'd1);
        chk("plan_ror1", y0, 64'h8000_0000_0000_0000);
        run(2'd1, 64'hB4, 64'd3);
        chk("plan_w8_asr3", 64'(y8), 64'hF6);
        ra = {$urandom, $urandom};
        run(2'd2, ra, 64'd0);
        chk("plan_amt0", y0, ra);

        // Backpressure: hold the result while a second request waits.
        ra = {$urandom, $urandom}; rb = 64'($urandom_range(0, 63)); ro = 2'($urandom);
        ea = model(ro, ra, rb, 1'b1, 64); ea1 = model(ro, ra, rb, 1'b0, 64);
        ea8 = model(ro, ra, rb, 1'b1, 8);
        send(ro, ra, rb);
        wait_done(ea, ea1, ea8);
        ra = {$urandom, $urandom}; rb = 64'($urandom_range(0, 63)); ro2 = 2'($urandom);
        eb = model(ro2, ra, rb, 1'b1, 64); eb1 = model(ro2, ra, rb, 1'b0, 64);
        eb8 = model(ro2, ra, rb, 1'b1, 8);
        @(negedge clk);
        op = ro2; a = ra; b = rb; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(ov0), 64'd1);
            chk("bp_y_stable", y0, ea);
            chk("bp_in_ready", 64'(ir0), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_idle", 64'({ir0, ov0, bz0}), 64'b100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accept", 64'({bz0, ir0}), 64'b10);
        wait_done(eb, eb1, eb8);
        drain();

        // Reset in the middle of stage 3, after a non-zero result.
        run(2'd1, 64'h8000_0000_0000_0000, 64'd64);
        send(2'd0, 64'hDEAD_BEEF_0123_4567, 64'd13);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_y", y0 | y1 | 64'(y8), 64'd0);
        chk("midreset_flags", 64'({ov0, ov1, ov8, bz0, bz1, bz8}), 64'd0);
        chk("midreset_in_ready", 64'({ir0, ir1, ir8}), 64'b111);
        @(negedge clk);
        rst_n = 1'b1;
        run(2'd3, 64'hDEAD_BEEF_0123_4567, 64'd13);

        // Random requests.
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'($urandom_range(0, 63));
                1:       rb = 64'($urandom_range(64, 70));
                2:       rb = {$urandom, $urandom};
                default: rb = 64'($urandom_range(0, 15)) | (64'($urandom_range(0, 1)) << 40);
            endcase
            run(2'($urandom), ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_nbit.md
Name: shift_seq_nbit

Overview:
- Multi-cycle, parametrised shifter; successor to the combinational fixed-width right shifters used as PIM synthesis benchmarks.
- Supports four modes: logical right, arithmetic right, logical left and rotate right.
- Resolves one barrel stage per cycle and holds its state in registers, so the per-cycle logic depth is one mux level.
- Uses valid/ready handshakes on both input and output, so it can sit between bit-serial PIM datapath stages.

Parameters:
- WIDTH, 64, data width in bits; must be a power of two and at least 2.
- SHIFT_WIDTH, $clog2(WIDTH), number of shift-amount bits resolved (one stage each).
- SATURATE, 1, when 1, a shift amount of WIDTH or more saturates (see Behaviour); when 0, only B[SHIFT_WIDTH-1:0] is used.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  2  mode: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- A  input  WIDTH  operand.
- B  input  WIDTH  shift amount, unsigned.
- out_valid  output  1  result Y valid.
- out_ready  input  1  consumer accepts Y.
- Y  output  WIDTH  result register.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, Y=0, out_valid=0, busy=0, stage counter=0, internal op/amount registers=0.
  - in_ready is combinationally high in IDLE, so it reads 1 during reset.
- States:
  - IDLE: in_ready=1.
    - A handshake (in_valid & in_ready) latches A into a working register, plus op and B[SHIFT_WIDTH-1:0]; state goes to SHIFT; counter k=0.
  - SHIFT: in_ready=0, busy=1.
    - Each cycle applies stage k: if amt[k]=1, shift the working register by 2^k in the latched mode.
      - Logical right: zero fill.
      - Arithmetic right: fill with the working register MSB.
      - Logical left: zero fill.
      - Rotate right: bits wrap around.
    - k increments each cycle. After stage SHIFT_WIDTH-1, state goes to DONE; Y is loaded with the final value and out_valid is set.
  - DONE: out_valid=1, Y is stable.
    - When out_ready=1, state goes to IDLE and out_valid is cleared on that edge.
    - Y keeps its last result until the next DONE load.
- Latency and throughput:
  - out_valid rises SHIFT_WIDTH cycles after the accept edge (6 cycles at WIDTH=64).
  - Latency is fixed and independent of amount and op. Stages with amt[k]=0 still consume a cycle.
  - Minimum request spacing is SHIFT_WIDTH+2 cycles. There is no accept while in DONE, even when out_ready=1 in the same cycle.
- Saturation (SATURATE=1, at the accept edge):
  - The check is whether any bit of B[WIDTH-1:SHIFT_WIDTH] is 1.
  - If so, and op is not rotate, the working register is loaded with the saturated value and amt is loaded as 0:
    - logical right or left: 0;
    - arithmetic right: all bits equal to A[WIDTH-1].
  - Rotate always uses B mod WIDTH.
  - Latency is unchanged.
- Inputs A, B and op are sampled only at the accept edge. Changes while busy are ignored.
- in_valid asserted while busy is ignored. The requester must hold its request until in_ready.
- out_ready asserted while not in DONE is ignored.
- Reset mid-operation (rst_n low in SHIFT or DONE): the operation is aborted with no output; all registers go to their reset values immediately.
- Amount 0 in any mode gives Y=A.

Test Plan:
- WIDTH=64, op=00, A=64'hF000_0000_0000_0001, B=4 -> Y=64'h0F00_0000_0000_0000; out_valid rises exactly 6 cycles after the accept edge.
- op=01, A=64'h8000_0000_0000_0000, B=63 -> Y=64'hFFFF_FFFF_FFFF_FFFF; the same A with op=00 -> Y=1.
- Saturation, B=64:
  - op=00, A=64'hFFFF_FFFF_FFFF_FFFF -> Y=0;
  - op=01, A=64'h8000_0000_0000_0000 -> all ones;
  - op=11, A=64'h1 -> Y=64'h1;
  - with SATURATE=0, op=00 -> Y=A.
- op=10, A=1, B=63 -> Y=64'h8000_0000_0000_0000; op=11, A=64'h1, B=1 -> Y=64'h8000_0000_0000_0000.
- Backpressure:
  - hold out_ready=0 for 10 cycles -> out_valid and Y stay stable, in_ready=0;
  - a second in_valid is not accepted;
  - out_ready=1 -> IDLE next cycle, and the second request is accepted on the following edge.
- Assert rst_n low mid-SHIFT (stage 3) -> Y=0, out_valid=0, in_ready=1 immediately; a new request afterwards completes correctly. Also check WIDTH=8, A=8'hB4, B=3, op=01 -> Y=8'hF6.
